bf_inv_op: RTL and testbench

- Inverse radix-2 butterfly: the decoder for the forward butterfly's (a+b, a−b) pair.
- Accepts one butterfly output pair (pa = a+b, pb = a−b) per handshake.
- Reconstructs a = (pa+pb)/2 and b = (pa−pb)/2.
- Emits a then b as a serial complex sample stream.
- Used on the IFFT/verification path to unwind a butterfly stage and feed a sample-serial consumer.

---
 rtl/bf_inv_op.sv | 160 ++++++++++++++++
 tb/tb_bf_inv_op.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_inv_op.sv
// Inverse radix-2 butterfly: takes a (a+b, a-b) pair and emits the
// reconstructed a then b as a complex sample stream with valid/ready handshakes.
module bf_inv_op #(
  parameter int DW    = 16,
  parameter bit SCALE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_pa,
  input  logic [2*DW-1:0] in_pb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic            out_sel,
  output logic            out_sat,
  output logic [15:0]     pair_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_t;

  state_t          state_reg;
  logic [2*DW-1:0] out_data_reg;
  logic            out_valid_reg;
  logic            out_sel_reg;
  logic            out_sat_reg;
  logic [15:0]     pair_cnt_reg;
  logic [2*DW-1:0] b_hold_reg;
  logic            b_sat_reg;

  wire  [2*DW-1:0] a_next;
  wire  [2*DW-1:0] b_next;
  wire  [1:0]      a_clip;
  wire  [1:0]      b_clip;
  logic            in_fire;
  logic            out_fire;

  // Clamp a DW+1 bit two's complement value into DW bits.
  function automatic logic [DW-1:0] clamp(input logic [DW:0] v);
    if (v[DW] != v[DW-1])
      clamp = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      clamp = v[DW-1:0];
  endfunction

  function automatic logic clipped(input logic [DW:0] v);
    clipped = (v[DW] != v[DW-1]);
  endfunction

  // gi = 1 is the real component (upper half), gi = 0 the imaginary one.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      logic [DW-1:0] pa_c;
      logic [DW-1:0] pb_c;
      logic [DW:0]   s;
      logic [DW:0]   d;

      assign pa_c = in_pa[gi*DW +: DW];
      assign pb_c = in_pb[gi*DW +: DW];
      assign s    = {pa_c[DW-1], pa_c} + {pb_c[DW-1], pb_c};
      assign d    = {pa_c[DW-1], pa_c} - {pb_c[DW-1], pb_c};

      if (SCALE) begin : g_half
        logic [DW:0] s_r;
        logic [DW:0] d_r;
        // (x+1)>>>1 == (x>>>1) + x[0]; only d = max-min can exceed DW bits.
        assign s_r = {s[DW], s[DW:1]} + {{DW{1'b0}}, s[0]};
        assign d_r = {d[DW], d[DW:1]} + {{DW{1'b0}}, d[0]};
        assign a_next[gi*DW +: DW] = clamp(s_r);
        assign b_next[gi*DW +: DW] = clamp(d_r);
        assign a_clip[gi] = 1'b0;
        assign b_clip[gi] = 1'b0;
      end else begin : g_sat
        assign a_next[gi*DW +: DW] = clamp(s);
        assign b_next[gi*DW +: DW] = clamp(d);
        assign a_clip[gi] = clipped(s);
        assign b_clip[gi] = clipped(d);
      end
    end
  endgenerate

  // In EMIT_B the slot frees exactly when b leaves, so ready passes through.
  assign in_ready = (state_reg == IDLE) || ((state_reg == EMIT_B) && out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sel_reg   <= 1'b0;
      out_sat_reg   <= 1'b0;
      pair_cnt_reg  <= '0;
      b_hold_reg    <= '0;
      b_sat_reg     <= 1'b0;
    end else if (clr) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_fire) begin
            out_data_reg  <= a_next;
            out_sat_reg   <= |a_clip;
            out_sel_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            b_hold_reg    <= b_next;
            b_sat_reg     <= |b_clip;
            state_reg     <= EMIT_A;
          end
        end
        EMIT_A: begin
          if (out_fire) begin
            out_data_reg <= b_hold_reg;
            out_sat_reg  <= b_sat_reg;
            out_sel_reg  <= 1'b1;
            state_reg    <= EMIT_B;
          end
        end
        EMIT_B: begin
          if (out_fire) begin
            pair_cnt_reg <= pair_cnt_reg + 16'd1;
            if (in_fire) begin
              out_data_reg <= a_next;
              out_sat_reg  <= |a_clip;
              out_sel_reg  <= 1'b0;
              b_hold_reg   <= b_next;
              b_sat_reg    <= |b_clip;
              state_reg    <= EMIT_A;
            end else begin
              out_valid_reg <= 1'b0;
              out_sel_reg   <= 1'b0;
              out_sat_reg   <= 1'b0;
              state_reg     <= IDLE;
            end
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_sat   = out_sat_reg;
  assign pair_cnt  = pair_cnt_reg;

endmodule

// File: tb/tb_bf_inv_op.sv
// Directed bench for bf_inv_op: one rounding instance (SCALE=1) and one
// saturating instance (SCALE=0) share the same stimulus and handshake.
module tb_bf_inv_op;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pa = '0;
  logic [31:0] in_pb = '0;

  logic        in_ready1, out_valid1, out_sel1, out_sat1;
  logic [31:0] out_data1;
  logic [15:0] pair_cnt1;
  logic        in_ready0, out_valid0, out_sel0, out_sat0;
  logic [31:0] out_data0;
  logic [15:0] pair_cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  bf_inv_op #(.DW(16), .SCALE(1'b1)) u_round (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pa(in_pa), .in_pb(in_pb),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_sel(out_sel1), .out_sat(out_sat1), .pair_cnt(pair_cnt1)
  );

  bf_inv_op #(.DW(16), .SCALE(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready0), .in_pa(in_pa), .in_pb(in_pb),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_sel(out_sel0), .out_sat(out_sat0), .pair_cnt(pair_cnt0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: round-half-up halving of a 16-bit sum or difference.
  function automatic logic [15:0] half(input logic [15:0] x, input logic [15:0] y, input bit sub);
    int s;
    int r;
    s = sub ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    r = (s + 1) >>> 1;
    if (r > 32767) r = 32767;
    return r[15:0];
  endfunction

  function automatic logic [31:0] model_a(input logic [31:0] pa, input logic [31:0] pb);
    return {half(pa[31:16], pb[31:16], 1'b0), half(pa[15:0], pb[15:0], 1'b0)};
  endfunction

  function automatic logic [31:0] model_b(input logic [31:0] pa, input logic [31:0] pb);
    return {half(pa[31:16], pb[31:16], 1'b1), half(pa[15:0], pb[15:0], 1'b1)};
  endfunction

  task automatic send(input logic [31:0] pa, input logic [31:0] pb);
    int n = 0;
    in_pa = pa;
    in_pb = pb;
    in_valid = 1'b1;
    #1;
    while (!in_ready1 && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready1, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag, input logic [31:0] e1, input logic [31:0] e0,
                      input bit esel, input bit esat0);
    int n = 0;
    out_ready = 1'b1;
    #1;
    while (!out_valid1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid1, 1);
    chk({tag, "_d1"}, out_data1, e1);
    chk({tag, "_sel"}, out_sel1, esel);
    chk({tag, "_sat1"}, out_sat1, 0);
    chk({tag, "_d0"}, out_data0, e0);
    chk({tag, "_sat0"}, out_sat0, esat0);
    $display("%s: sel=%0d round=%h sat_data=%h sat=%0d", tag, out_sel1, out_data1, out_data0, out_sat0);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic stream(input string tag, input int npairs, input bit rnd);
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [31:0] pa, pb, held;
    logic        held_sel;
    bit          stalled = 1'b0;
    int idx = 0, got = 0, cyc = 0, first = -1, last = -1;
    while (got < 2 * npairs && cyc < 4000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pa = {16'(idx * 4111 + 7), 16'(16'hF000 - idx * 977)};
      pb = {16'(idx * 2503 + 11), 16'(idx * 613 + 3)};
      in_valid = (idx < npairs);
      in_pa = pa;
      in_pb = pb;
      #1;
      if (stalled)
        chk({tag, "_hold"}, {out_valid1, out_sel1, out_data1}, {1'b1, held_sel, held});
      if (!rnd)
        chk({tag, "_in_ready"}, in_ready1, (!out_valid1) || (out_sel1 && out_ready));
      if (out_valid1 && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_out"}, {out_sel1, out_data1}, e);
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
        if (out_sel1) $display("%s: pair %0d b=%h", tag, got / 2, out_data1);
      end
      stalled  = out_valid1 && !out_ready;
      held     = out_data1;
      held_sel = out_sel1;
      if (in_valid && in_ready1) begin
        exp_q.push_back({1'b0, model_a(pa, pb)});
        exp_q.push_back({1'b1, model_b(pa, pb)});
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_count"}, got, 2 * npairs);
    if (!rnd) chk({tag, "_contig"}, last - first + 1, 2 * npairs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;

    // Reset values while rst_n is held low
    #12;
    chk("rst_valid", out_valid1, 0);
    chk("rst_data", out_data1, 0);
    chk("rst_sel", out_sel1, 0);
    chk("rst_sat", out_sat0, 0);
    chk("rst_cnt", pair_cnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready1, 1);
    chk("rst_out_valid", out_valid1, 0);

    // Basic inverse: pa=(300,-40) pb=(100,20)
    send({16'h012C, 16'hFFD8}, {16'h0064, 16'h0014});
    chk("latency_a", out_valid1, 1);
    take("basic_a", {16'h00C8, 16'hFFF6}, {16'h0190, 16'hFFEC}, 1'b0, 1'b0);
    take("basic_b", {16'h0064, 16'hFFE2}, {16'h00C8, 16'hFFC4}, 1'b1, 1'b0);
    chk("basic_cnt", pair_cnt1, 1);

    // Rounding: pa=(3,-3) pb=(0,0)
    send({16'h0003, 16'hFFFD}, 32'h0);
    take("round_a", {16'h0002, 16'hFFFF}, {16'h0003, 16'hFFFD}, 1'b0, 1'b0);
    take("round_b", {16'h0002, 16'hFFFF}, {16'h0003, 16'hFFFD}, 1'b1, 1'b0);

    // Extremes: pa=pb=(0x7FFF,0x8000)
    send({16'h7FFF, 16'h8000}, {16'h7FFF, 16'h8000});
    take("ext_a", {16'h7FFF, 16'h8000}, {16'h7FFF, 16'h8000}, 1'b0, 1'b1);
    take("ext_b", 32'h0, 32'h0, 1'b1, 1'b0);

    // Saturation: pa=(0x7000,0x9000) pb=(0x2000,0x2000)
    send({16'h7000, 16'h9000}, {16'h2000, 16'h2000});
    take("sat_a", {16'h4800, 16'hD800}, {16'h7FFF, 16'hB000}, 1'b0, 1'b1);
    take("sat_b", {16'h2800, 16'hB800}, {16'h5000, 16'h8000}, 1'b1, 1'b1);
    chk("directed_cnt", pair_cnt1, 4);

    base = pair_cnt1;
    stream("stream", 8, 1'b0);
    chk("stream_cnt", pair_cnt1, base + 16'd8);

    base = pair_cnt1;
    stream("bp", 100, 1'b1);
    chk("bp_cnt", pair_cnt1, base + 16'd100);

    // clr while stalled in EMIT_B, with a competing input
    base = pair_cnt1;
    out_ready = 1'b0;
    send({16'h0100, 16'h0200}, {16'h0010, 16'h0020});
    out_ready = 1'b1;
    tick();
    chk("clr_pre_sel", out_sel1, 1);
    out_ready = 1'b0;
    clr = 1'b1;
    in_valid = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_valid", out_valid1, 0);
    chk("clr_in_ready", in_ready1, 1);
    chk("clr_cnt", pair_cnt1, base);

    // clr in IDLE discards an input even though in_ready=1
    clr = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("clr_idle_ready", in_ready1, 1);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_drop", out_valid1, 0);
    tick();
    chk("clr_drop2", out_valid1, 0);

    // Asynchronous reset in the middle of EMIT_A
    send({16'h1234, 16'h5678}, {16'h0101, 16'h0202});
    chk("arst_pre", out_valid1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid1, 0);
    chk("arst_data", out_data1, 0);
    chk("arst_cnt", pair_cnt1, 0);
    chk("arst_in_ready", in_ready1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_after", out_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
